// File: rtl/rstmgr_pkg.sv
// rtl/rstmgr_pkg.sv - shared reset-manager types for the leaf software-reset initiator
package rstmgr_pkg;

  localparam int SwRstReqCntW = 8;

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  // Sparse encoding so a single upset lands on an invalid code and is caught.
  typedef enum logic [4:0] {
    StIdle      = 5'b01101,
    StAssertReq = 5'b10011,
    StHold      = 5'b00110,
    StRelease   = 5'b11000
  } sw_rst_req_state_e;

endpackage

// File: rtl/rstmgr_sw_rst_req_if.sv
// rtl/rstmgr_sw_rst_req_if.sv - software-reset request/status bundle between rstmgr logic and the initiator
interface rstmgr_sw_rst_req_if;
  import rstmgr_pkg::*;

  logic                    en_i;
  logic                    req_i;
  logic [3:0]              rst_en_i;
  logic                    sw_rst_req_no;
  logic                    busy_o;
  logic                    done_o;
  logic                    timeout_err_o;
  logic                    mubi_err_o;
  logic [SwRstReqCntW-1:0] req_cnt_o;

  modport master (
    output en_i, req_i, rst_en_i,
    input  sw_rst_req_no, busy_o, done_o, timeout_err_o, mubi_err_o, req_cnt_o
  );

  modport slave (
    input  en_i, req_i, rst_en_i,
    output sw_rst_req_no, busy_o, done_o, timeout_err_o, mubi_err_o, req_cnt_o
  );

endinterface

// File: rtl/prim_flop_2sync.sv
// rtl/prim_flop_2sync.sv - two-flop synchroniser with configurable reset value
module prim_flop_2sync #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/rstmgr_sw_rst_req.sv
// rtl/rstmgr_sw_rst_req.sv - paces a leaf software reset: assert, confirm, hold, release, confirm.
// Optional completed-request counter enabled by RSTMGR_SW_RST_REQ_CNT_EN.
module rstmgr_sw_rst_req
  import rstmgr_pkg::*;
#(
  parameter int  HoldCycles    = 4,
  parameter int  TimeoutCycles = 1024,
  localparam int CntW          = $clog2(TimeoutCycles + 1)
) (
  input logic               clk_i,
  input logic               rst_i,
  rstmgr_sw_rst_req_if.slave bus
);

  localparam logic [CntW-1:0] HoldLast    = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  logic [3:0] rst_en_q;

  for (genvar i = 0; i < 4; i++) begin : g_sync
    prim_flop_2sync #(
      .Width      (1),
      .ResetValue (MuBi4True[i])
    ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (bus.rst_en_i[i]),
      .q_o   (rst_en_q[i])
    );
  end

  logic asserted, released;
  assign asserted = (rst_en_q == MuBi4True);
  assign released = (rst_en_q == MuBi4False);

  sw_rst_req_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              req_nq, req_nd;
  logic              done_q, done_d;
  logic              timeout_q, timeout_set;
  logic              mubi_err_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      // A request landing in the done_o cycle is dropped like any busy-time request.
      StIdle: begin
        if (bus.req_i && bus.en_i && !done_q) begin
          state_d = StAssertReq;
          cnt_d   = '0;
        end
      end
      StAssertReq: begin
        if (asserted) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease: begin
        if (released) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d     = StIdle;
        cnt_d       = '0;
        timeout_set = 1'b1;
      end
    endcase
  end

  // The request output is a flop loaded from the next state, so it never glitches.
  assign req_nd = !((state_d == StAssertReq) || (state_d == StHold));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_nq     <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mubi_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_nq     <= req_nd;
      done_q     <= done_d;
      timeout_q  <= timeout_q | timeout_set;
      mubi_err_q <= !(asserted || released);
    end
  end

`ifdef RSTMGR_SW_RST_REQ_CNT_EN
  logic [SwRstReqCntW-1:0] req_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_cnt_q <= '0;
    end else if (done_d && (req_cnt_q != '1)) begin
      req_cnt_q <= req_cnt_q + 1'b1;
    end
  end

  assign bus.req_cnt_o = req_cnt_q;
`else
  assign bus.req_cnt_o = '0;
`endif

  assign bus.sw_rst_req_no = req_nq;
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.done_o        = done_q;
  assign bus.timeout_err_o = timeout_q;
  assign bus.mubi_err_o    = mubi_err_q;

endmodule

// File: tb/tb_rstmgr_sw_rst_req.sv
// tb/tb_rstmgr_sw_rst_req.sv - directed bench for rstmgr_sw_rst_req (HoldCycles=4, TimeoutCycles=16)
module tb_rstmgr_sw_rst_req;

  localparam logic [3:0] TRUE4  = 4'h6;
  localparam logic [3:0] FALSE4 = 4'h9;

`ifdef RSTMGR_SW_RST_REQ_CNT_EN
  localparam logic [7:0] ONE_REQ = 8'd1;
`else
  localparam logic [7:0] ONE_REQ = 8'd0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  rstmgr_sw_rst_req_if bif ();

  rstmgr_sw_rst_req #(
    .HoldCycles    (4),
    .TimeoutCycles (16)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int low_cnt, hi_cnt, t_true;

  // Behavioural leaf: confirms reset 3 cycles into the request, clears 3 cycles after release.
  task automatic leaf_step(input int n);
    if (!bif.sw_rst_req_no) begin
      hi_cnt = 0;
      low_cnt++;
      if (low_cnt == 3) begin
        bif.rst_en_i = TRUE4;
        t_true = n;
      end
    end else begin
      low_cnt = 0;
      hi_cnt++;
      if (hi_cnt == 3) bif.rst_en_i = FALSE4;
    end
  endtask

  task automatic test_reset;
    bif.en_i = 1'b1; bif.req_i = 1'b0; bif.rst_en_i = FALSE4;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    vectors++; if (bif.sw_rst_req_no !== 1'b1) begin miscompares++; $display("FAIL reset_req_n: got %b want 1", bif.sw_rst_req_no); end
    vectors++; if (bif.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bif.busy_o); end
    vectors++; if (bif.done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bif.done_o); end
    vectors++; if (bif.timeout_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", bif.timeout_err_o); end
    vectors++; if (bif.mubi_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_mubi: got %b want 0", bif.mubi_err_o); end
    vectors++; if (bif.req_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bif.req_cnt_o); end
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    vectors++; if (bif.busy_o !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b want 0", bif.busy_o); end
  endtask

  task automatic test_normal;
    int low_tot = 0, hold_low = 0, done_n = 0, done_at = -1;
    low_cnt = 0; hi_cnt = 0; t_true = 1000;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_i);
      bif.req_i = 1'b0;
      if (!bif.sw_rst_req_no) begin
        low_tot++;
        if (n > t_true + 2) hold_low++;
      end
      if (bif.done_o) begin done_n++; if (done_at < 0) done_at = n; end
      leaf_step(n);
    end
    vectors++; if (low_tot != 9) begin miscompares++; $display("FAIL normal_low_total: got %0d want 9", low_tot); end
    vectors++; if (hold_low != 4) begin miscompares++; $display("FAIL normal_hold_low: got %0d want 4", hold_low); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL normal_done_count: got %0d want 1", done_n); end
    vectors++; if (done_at != 15) begin miscompares++; $display("FAIL normal_done_cycle: got %0d want 15", done_at); end
    vectors++; if (bif.req_cnt_o !== ONE_REQ) begin miscompares++; $display("FAIL normal_req_cnt: got %0d want %0d", bif.req_cnt_o, ONE_REQ); end
    vectors++; if (bif.busy_o !== 1'b0) begin miscompares++; $display("FAIL normal_busy_end: got %b want 0", bif.busy_o); end
  endtask

  task automatic test_disabled;
    int bad_req = 0, bad_busy = 0, done_n = 0;
    bif.en_i = 1'b0;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk_i);
      bif.req_i = 1'b0;
      if (bif.sw_rst_req_no !== 1'b1) bad_req++;
      if (bif.busy_o !== 1'b0) bad_busy++;
      if (bif.done_o) done_n++;
    end
    bif.en_i = 1'b1;
    vectors++; if (bad_req != 0) begin miscompares++; $display("FAIL disabled_req_n: got %0d low cycles want 0", bad_req); end
    vectors++; if (bad_busy != 0) begin miscompares++; $display("FAIL disabled_busy: got %0d busy cycles want 0", bad_busy); end
    vectors++; if (done_n != 0) begin miscompares++; $display("FAIL disabled_done: got %0d want 0", done_n); end
  endtask

  task automatic test_mubi_err;
    int err_n = 0, err_at = -1, done_n = 0, done_at = -1;
    low_cnt = 0; hi_cnt = 0; t_true = 1000;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_i);
      bif.req_i = 1'b0;
      if (bif.mubi_err_o) begin err_n++; if (err_at < 0) err_at = n; end
      if (bif.done_o) begin done_n++; if (done_at < 0) done_at = n; end
      leaf_step(n);
      if (n == 2 || n == 3) bif.rst_en_i = 4'b0000;
      if (n == 4) bif.rst_en_i = TRUE4;
    end
    vectors++; if (err_n != 2) begin miscompares++; $display("FAIL mubi_err_count: got %0d want 2", err_n); end
    vectors++; if (err_at != 5) begin miscompares++; $display("FAIL mubi_err_cycle: got %0d want 5", err_at); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL mubi_done_count: got %0d want 1", done_n); end
    vectors++; if (done_at != 16) begin miscompares++; $display("FAIL mubi_done_cycle: got %0d want 16", done_at); end
    vectors++; if (bif.timeout_err_o !== 1'b0) begin miscompares++; $display("FAIL mubi_timeout: got %b want 0", bif.timeout_err_o); end
  endtask

  task automatic test_timeout;
    int low_tot = 0, to_at = -1, done_n = 0;
    bif.rst_en_i = FALSE4;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk_i);
      bif.req_i = 1'b0;
      if (!bif.sw_rst_req_no) low_tot++;
      if (bif.timeout_err_o && to_at < 0) to_at = n;
      if (bif.done_o) done_n++;
    end
    vectors++; if (low_tot != 16) begin miscompares++; $display("FAIL timeout_low_total: got %0d want 16", low_tot); end
    vectors++; if (to_at != 17) begin miscompares++; $display("FAIL timeout_cycle: got %0d want 17", to_at); end
    vectors++; if (done_n != 0) begin miscompares++; $display("FAIL timeout_done: got %0d want 0", done_n); end
    vectors++; if (bif.timeout_err_o !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", bif.timeout_err_o); end
    vectors++; if (bif.sw_rst_req_no !== 1'b1) begin miscompares++; $display("FAIL timeout_req_n: got %b want 1", bif.sw_rst_req_no); end
  endtask

  task automatic test_rst_mid;
    low_cnt = 0; hi_cnt = 0; t_true = 1000;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk_i);
      bif.req_i = 1'b0;
      leaf_step(n);
    end
    vectors++; if (bif.sw_rst_req_no !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pre_req_n: got %b want 0", bif.sw_rst_req_no); end
    rst_i = 1'b1;
    #1;
    vectors++; if (bif.sw_rst_req_no !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req_n: got %b want 1", bif.sw_rst_req_no); end
    vectors++; if (bif.busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", bif.busy_o); end
    vectors++; if (bif.timeout_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_timeout: got %b want 0", bif.timeout_err_o); end
    vectors++; if (bif.req_cnt_o !== 8'd0) begin miscompares++; $display("FAIL rst_mid_cnt: got %0d want 0", bif.req_cnt_o); end
    vectors++; if (bif.done_o !== 1'b0 || bif.mubi_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pulses: got done=%b mubi=%b want 0 0", bif.done_o, bif.mubi_err_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    bif.rst_en_i = FALSE4;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    int done_n = 0, late_busy = 0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    low_cnt = 0; hi_cnt = 0; t_true = 1000;
    bif.req_i = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_i);
      if (bif.done_o) done_n++;
      if (n >= 16 && bif.busy_o) late_busy++;
      bif.req_i = (n == 2 || n == 5 || n == 8 || bif.done_o);
      leaf_step(n);
    end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 1", done_n); end
    vectors++; if (late_busy != 0) begin miscompares++; $display("FAIL b2b_req_at_done: got %0d busy cycles want 0", late_busy); end
    vectors++; if (bif.req_cnt_o !== ONE_REQ) begin miscompares++; $display("FAIL b2b_req_cnt: got %0d want %0d", bif.req_cnt_o, ONE_REQ); end
    vectors++; if (bif.timeout_err_o !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout: got %b want 0", bif.timeout_err_o); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_disabled();
    test_mubi_err();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
